// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the MEM-protocol SRAM responder.
// Imported by mem_resp_array and mem_sram_responder.
package mem_resp_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned NUM_BYTES   = WORD_W / BYTE_W;
    localparam int unsigned MAX_LATENCY = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_resp_array.sv
// Single-port byte-enabled SRAM: synchronous write, synchronous registered read.
// Written so that synthesis tools map it onto block RAM.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [NUM_BYTES-1:0]     be_i,
    input  logic [WORD_W-1:0]        wdata_i,
    output logic [WORD_W-1:0]        rdata_o
);

    logic [NUM_BYTES-1:0][BYTE_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0]                rdata_q;

    // NOTE: the storage array and its read register carry no reset; a reset
    // network on the array would prevent block-RAM inference.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][i] <= wdata_i[i*BYTE_W +: BYTE_W];
                end
            end
        end
        // Read register only loads on a read, so it holds the word until consumed.
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_sram_responder.sv
// MEM-protocol slave backed by on-chip SRAM, single outstanding transaction,
// fixed LATENCY. Define MEM_RESP_ADDR_CHECK_EN to enable the address range check.
module mem_sram_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 mem_req_i,
    output logic                 mem_gnt_o,
    input  logic [31:0]          mem_addr_i,
    input  logic                 mem_we_i,
    input  logic [NUM_BYTES-1:0] mem_be_i,
    input  logic [WORD_W-1:0]    mem_wdata_i,
    output logic                 mem_valid_o,
    output logic [WORD_W-1:0]    mem_rdata_o,
    output logic                 mem_error_o
);

    localparam int unsigned      AW       = $clog2(DEPTH);
    localparam int unsigned      CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt;
    logic [31:0]       offset;
    logic [AW-1:0]     index;
    logic              addr_err;
    logic              pend_we_q;
    logic              resp_we;
    logic              resp_err;
    logic              valid_q;
    logic              rdata_sel_q;
    logic              arr_we;
    logic              arr_re;
    logic [WORD_W-1:0] arr_rdata;
    logic              unused_addr_bits;

    // Grant is forced low during reset even though the FSM already sits in IDLE.
    assign gnt       = rst_ni && (state_q == IDLE) && mem_req_i;
    assign mem_gnt_o = gnt;

    assign offset = mem_addr_i - BASE_ADDR;
    assign index  = offset[AW+1:2];

`ifdef MEM_RESP_ADDR_CHECK_EN
    localparam logic [32:0] ADDR_SPAN = 33'(DEPTH) * 33'd4;

    logic pend_err_q;
    logic err_q;

    // Unsigned offset compare also catches addresses below BASE_ADDR (they wrap high).
    assign addr_err         = ({1'b0, offset} >= ADDR_SPAN);
    assign resp_err         = gnt ? addr_err : pend_err_q;
    assign unused_addr_bits = ^offset[1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_err_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (gnt) begin
                pend_err_q <= addr_err;
            end
            err_q <= (state_d == RESP) && resp_err;
        end
    end

    assign mem_error_o = err_q;
`else
    assign addr_err         = 1'b0;
    assign resp_err         = 1'b0;
    assign unused_addr_bits = ^{offset[31:AW+2], offset[1:0]};
    assign mem_error_o      = 1'b0;
`endif

    // With LATENCY = 1 the response is decided in the grant cycle itself,
    // before the pending registers have captured the request.
    assign resp_we = gnt ? mem_we_i : pend_we_q;

    assign arr_we = gnt && mem_we_i && !addr_err;
    assign arr_re = gnt && !mem_we_i && !addr_err;

    mem_resp_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (index),
        .be_i    (mem_be_i),
        .wdata_i (mem_wdata_i),
        .rdata_o (arr_rdata)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (gnt) begin
                    state_d = (LATENCY > 1) ? WAIT : RESP;
                    cnt_d   = (LATENCY > 1) ? CNT_W'(1) : '0;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_we_q   <= 1'b0;
            valid_q     <= 1'b0;
            rdata_sel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (gnt) begin
                pend_we_q <= mem_we_i;
            end
            valid_q     <= (state_d == RESP);
            rdata_sel_q <= (state_d == RESP) && !resp_we && !resp_err;
        end
    end

    // The array read register is the response register; the registered select
    // zeroes rdata outside successful read responses and while in reset.
    assign mem_valid_o = valid_q;
    assign mem_rdata_o = rdata_sel_q ? arr_rdata : '0;

endmodule

// File: tb/tb_mem_sram_responder.sv
// Directed bench for mem_sram_responder: one LATENCY=1 and one LATENCY=4 instance,
// table-driven transactions plus hand-written throughput and reset sequences.
module tb_mem_sram_responder;

    localparam logic [31:0] BASE = 32'h2000_0000;
`ifdef MEM_RESP_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] off;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req   [2];
    logic        gnt   [2];
    logic [31:0] addr  [2];
    logic        we    [2];
    logic [3:0]  be    [2];
    logic [31:0] wdata [2];
    logic        valid [2];
    logic [31:0] rdata [2];
    logic        err   [2];

    int checks   = 0;
    int failures = 0;
    int lat_of [2] = '{1, 4};

    vec_t vecs [13];

    always #5 clk = ~clk;

    mem_sram_responder #(.DEPTH(1024), .LATENCY(1), .BASE_ADDR(BASE)) dut_l1 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req[0]), .mem_gnt_o(gnt[0]),
        .mem_addr_i(addr[0]), .mem_we_i(we[0]), .mem_be_i(be[0]), .mem_wdata_i(wdata[0]),
        .mem_valid_o(valid[0]), .mem_rdata_o(rdata[0]), .mem_error_o(err[0])
    );

    mem_sram_responder #(.DEPTH(1024), .LATENCY(4), .BASE_ADDR(BASE)) dut_l4 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req[1]), .mem_gnt_o(gnt[1]),
        .mem_addr_i(addr[1]), .mem_we_i(we[1]), .mem_be_i(be[1]), .mem_wdata_i(wdata[1]),
        .mem_valid_o(valid[1]), .mem_rdata_o(rdata[1]), .mem_error_o(err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("%s_s%0d_gnt", tag, s), {31'b0, gnt[s]}, 32'd0);
            check($sformatf("%s_s%0d_valid", tag, s), {31'b0, valid[s]}, 32'd0);
            check($sformatf("%s_s%0d_rdata", tag, s), rdata[s], 32'd0);
            check($sformatf("%s_s%0d_err", tag, s), {31'b0, err[s]}, 32'd0);
        end
    endtask

    // Issues one request at the next falling edge and holds it through the
    // response cycle; returns during the valid cycle with req still asserted.
    task automatic txn(input int s, input string name, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
        int g;
        bit got;
        g   = -1;
        got = 1'b0;
        @(negedge clk);
        req[s] = 1'b1; we[s] = w; be[s] = b; addr[s] = a; wdata[s] = wd;
        for (int cyc = 0; cyc < 20 && !got; cyc++) begin
            #1;
            if (valid[s]) begin
                got = 1'b1;
                check({name, "_gnt_cyc"}, g, 0);
                check({name, "_latency"}, cyc - g, lat_of[s]);
                check({name, "_rdata"}, rdata[s], exp_rd);
                check({name, "_err"}, {31'b0, err[s]}, {31'b0, exp_err});
                check({name, "_no_gnt_in_resp"}, {31'b0, gnt[s]}, 32'd0);
            end else begin
                if (gnt[s] && g < 0) g = cyc;
                @(negedge clk);
            end
        end
        if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic release_req(input int s);
        @(negedge clk);
        req[s] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] gm;
        logic [10:0] vm;
        bit          any_valid;

        //            we    be       off           wd             exp_rd                          exp_err
        vecs[0]  = '{1'b1, 4'hF,    32'h0000,     32'h0123_4567, 32'h0,                          1'b0};
        vecs[1]  = '{1'b1, 4'hF,    32'h0004,     32'h89AB_CDEF, 32'h0,                          1'b0};
        vecs[2]  = '{1'b0, 4'hF,    32'h0000,     32'h0,         32'h0123_4567,                  1'b0};
        vecs[3]  = '{1'b0, 4'hF,    32'h0006,     32'h0,         32'h89AB_CDEF,                  1'b0};
        vecs[4]  = '{1'b1, 4'b1000, 32'h0004,     32'hFF00_0000, 32'h0,                          1'b0};
        vecs[5]  = '{1'b0, 4'hF,    32'h0004,     32'h0,         32'hFFAB_CDEF,                  1'b0};
        vecs[6]  = '{1'b1, 4'h0,    32'h0000,     32'hFFFF_FFFF, 32'h0,                          1'b0};
        vecs[7]  = '{1'b0, 4'hF,    32'h0000,     32'h0,         32'h0123_4567,                  1'b0};
        vecs[8]  = '{1'b1, 4'hF,    32'h0FFC,     32'hCAFE_F00D, 32'h0,                          1'b0};
        vecs[9]  = '{1'b0, 4'hF,    32'h0FFC,     32'h0,         32'hCAFE_F00D,                  1'b0};
        vecs[10] = '{1'b1, 4'hF,    32'h1000,     32'h5555_AAAA, 32'h0,                          CHK};
        vecs[11] = '{1'b0, 4'hF,    32'h0000,     32'h0,         CHK ? 32'h0123_4567 : 32'h5555_AAAA, 1'b0};
        vecs[12] = '{1'b0, 4'hF,    32'h1004,     32'h0,         CHK ? 32'h0 : 32'hFFAB_CDEF,    CHK};

        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b1; we[s] = 1'b0; be[s] = 4'h0; addr[s] = BASE; wdata[s] = 32'h0;
        end

        // Reset with requests pending: grant must be held low.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        req[0] = 1'b0; req[1] = 1'b0;
        rst_n = 1'b1;

        // Basic write/read and byte-enable merge on the LATENCY=1 instance.
        txn(0, "l1_wr_beef", 1'b1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        txn(0, "l1_rd_beef", 1'b0, 4'hF, BASE + 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        txn(0, "l1_wr_full", 1'b1, 4'hF, BASE + 32'h10, 32'h1122_3344, 32'h0, 1'b0);
        txn(0, "l1_wr_part", 1'b1, 4'b0101, BASE + 32'h10, 32'hAABB_CCDD, 32'h0, 1'b0);
        txn(0, "l1_rd_merge", 1'b0, 4'hF, BASE + 32'h10, 32'h0, 32'h11BB_33DD, 1'b0);
        release_req(0);

        // Shared vector table on both latencies.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 13; i++) begin
                txn(s, $sformatf("vec%0d_s%0d", i, s), vecs[i].we, vecs[i].be,
                    BASE + vecs[i].off, vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_err);
            end
            release_req(s);
        end

        // LATENCY=4 with req held continuously: grants at 0,5,10; valid at 4,9.
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = BASE + 32'h4;
        gm = '0;
        vm = '0;
        for (int c = 0; c < 11; c++) begin
            #1;
            gm[c] = gnt[1];
            vm[c] = valid[1];
            if (valid[1]) check($sformatf("cont_rdata_c%0d", c), rdata[1], 32'hFFAB_CDEF);
            @(negedge clk);
        end
        req[1] = 1'b0;
        check("cont_gnt_pattern", {21'b0, gm}, {21'b0, 11'b100_0010_0001});
        check("cont_valid_pattern", {21'b0, vm}, {21'b0, 11'b010_0001_0000});
        repeat (6) @(negedge clk);

        // Reset at T+2 of a LATENCY=4 write: no response, write stays committed.
        req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = BASE + 32'h20; wdata[1] = 32'h7777_8888;
        #1;
        check("rst_seq_gnt_T", {31'b0, gnt[1]}, 32'd1);
        @(negedge clk);
        #1;
        check("rst_seq_valid_T1", {31'b0, valid[1]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid_a");
        @(negedge clk);
        #1;
        check_outputs_zero("rst_mid_b");
        @(negedge clk);
        rst_n = 1'b1;
        req[1] = 1'b0;
        any_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (valid[1]) any_valid = 1'b1;
            @(negedge clk);
        end
        check("rst_no_valid_after", {31'b0, any_valid}, 32'd0);
        txn(1, "rst_rd_back", 1'b0, 4'hF, BASE + 32'h20, 32'h0, 32'h7777_8888, 1'b0);
        release_req(1);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_sram_responder.md
# mem_sram_responder

MEM-protocol slave (responder) backed by a byte-enabled, word-addressed on-chip SRAM. It terminates one instruction or data MEM master port of a core wrapper, serving single-outstanding read and write transactions with a fixed, parameterised response latency. It is used as local instruction/data memory and as a bench responder for core wrappers.

## Interface

Parameters:
- DEPTH, 1024: memory size in 32-bit words; power of two, ≥ 4.
- LATENCY, 1: cycles from grant cycle to valid cycle; legal range 1..8.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; DEPTH*4-aligned.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- mem_req_i  in  1  request from master; held by master until mem_valid_o.
- mem_gnt_o  out  1  request accepted this cycle.
- mem_addr_i  in  32  byte address; bits [1:0] ignored.
- mem_we_i  in  1  1 = write, 0 = read.
- mem_be_i  in  4  byte enables for writes.
- mem_wdata_i  in  32  write data.
- mem_valid_o  out  1  one-cycle response strobe.
- mem_rdata_o  out  32  read data, meaningful only while mem_valid_o = 1.
- mem_error_o  out  1  response error, meaningful only while mem_valid_o = 1.

## Operation

- FSM states: IDLE, WAIT, RESP.
- IDLE: mem_gnt_o = mem_req_i. On grant, capture we/index; next state RESP if LATENCY = 1, else WAIT.
- WAIT: latency counter (width $clog2(LATENCY+1)) advances each cycle; enter RESP so that valid occurs exactly LATENCY cycles after the grant cycle.
- RESP: mem_valid_o = 1 for one cycle, mem_gnt_o = 0 regardless of mem_req_i (master still holds req this cycle); next state IDLE.
- Exactly one outstanding transaction; no grant in WAIT or RESP.
- Write: committed at the clock edge ending the grant cycle, per byte lane where mem_be_i[i] = 1; be = 4'b0000 with we = 1 is a legal no-op write. Write response: rdata = 0.
- Read: array read in grant cycle, result held in a response register until RESP; subsequent writes cannot alter it (none can be accepted).
- Index = (mem_addr_i − BASE_ADDR) >> 2.

## Timing

- Reset values: state IDLE, mem_gnt_o = 0 (forced 0 while rst_ni = 0), mem_valid_o = 0, mem_rdata_o = 0, mem_error_o = 0, counter = 0. Array contents not reset.
- mem_gnt_o combinational from mem_req_i and state; mem_valid_o, mem_rdata_o, mem_error_o registered.
- Throughput: one transaction per LATENCY+1 cycles under continuous requests.
- Grant cycle T → valid at T+LATENCY → earliest next grant at T+LATENCY+1.
- Reset asserted mid-transaction: in-flight response discarded, no valid issued; a write granted before reset remains committed.
- mem_req_i dropped by master during WAIT: response still issued (protocol violation, not checked).

## Configuration

- MEM_RESP_ADDR_CHECK_EN defined: address outside [BASE_ADDR, BASE_ADDR + DEPTH*4) is granted normally, completes with mem_error_o = 1, mem_rdata_o = 0, write suppressed.
- Not defined: no range check; index uses low $clog2(DEPTH) bits (wrap-around aliasing); mem_error_o tied 0.

## Structure

- Package mem_resp_pkg: FSM state enum (IDLE, WAIT, RESP), word-width and byte-lane constants, MAX_LATENCY = 8.
- Sub-module mem_resp_array: single-port byte-enabled 32-bit SRAM, synchronous write, synchronous read, DEPTH parameter, inferable as BRAM.

## Test plan

- LATENCY=1: write 32'hDEAD_BEEF be 4'hF @ BASE+0x10, then read @ BASE+0x10 → gnt on request cycle, valid one cycle later, rdata 32'hDEAD_BEEF, error 0.
- Byte enables: write 32'h1122_3344 be 4'hF, then 32'hAABB_CCDD be 4'b0101 same address; read → 32'h11BB_33DD.
- LATENCY=4, req held high continuously (Pico-style): grants at T, T+5, T+10; valid at T+4, T+9; no grant during RESP cycles.
- MEM_RESP_ADDR_CHECK_EN defined, DEPTH=1024: write @ BASE+0x1000 → valid with error 1; read @ BASE+0x0 unchanged; without macro the same write aliases to word 0 and error stays 0.
- Reset pulse at T+2 of a LATENCY=4 read: no valid ever issued, all outputs 0 during reset, next request after release granted in IDLE.
